noc_outport_arbiter: RTL

Round-robin arbiter and two-entry virtual-channel output buffer for one output port of a mesh4x4 router. It shares the port among the router's five input requesters (PE, N, S, E, W). Each 64-bit packet is steered into the even or odd VC buffer by packet bit 63. The port drains only the VC that matches the network-wide `polarity`, which keeps fill and drain on opposite VCs in every cycle.

---
 rtl/noc_outport_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/noc_outport_arbiter.sv
// Output-port arbiter for one mesh router port: round-robin grant among NREQ requesters
// into a two-entry VC buffer (even/odd), draining only the VC selected by the mesh polarity.
module noc_outport_arbiter #(
  parameter int DW   = 64,
  parameter int NREQ = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_polarity,
  input  logic [NREQ-1:0]    i_req_valid,
  input  logic [NREQ*DW-1:0] i_req_data,
  output logic [NREQ-1:0]    o_req_grant,
  input  logic               i_out_ready,
  output logic               o_out_send,
  output logic [DW-1:0]      o_out_data,
  output logic [1:0]         o_vc_full
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

  logic [DW-1:0] r_buf    [2];
  logic [1:0]    r_full;
  logic [PW-1:0] r_rr_ptr [2];

  logic          w_fill_vc;
  logic          w_drain_vc;
  logic [NREQ-1:0] w_elig;
  logic [PW-1:0] w_start;
  logic [PW-1:0] w_win;
  logic          w_found;
  logic          w_fill;
  logic [PW-1:0] w_ptr_next;
  logic [DW-1:0] w_win_data;

  assign w_fill_vc  = ~i_polarity;
  assign w_drain_vc = i_polarity;

  // A request is only eligible on the phase where its VC is the fill VC.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_elig
      assign w_elig[gi] = i_req_valid[gi] & (i_req_data[gi*DW + DW - 1] == w_fill_vc);
    end
  endgenerate

  assign w_start = r_rr_ptr[w_fill_vc];

  // Wrapping scan starting at the fill VC's pointer; first eligible index wins.
  always_comb begin
    int w_idx;
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(w_start) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = PW'(w_idx);
      end
    end
  end

  // Grant is suppressed while reset is held so outputs read idle immediately.
  assign w_fill     = w_found & ~r_full[w_fill_vc] & rst_n;
  assign w_ptr_next = (w_win == LAST_IDX) ? '0 : w_win + 1'b1;
  assign w_win_data = i_req_data[int'(w_win)*DW +: DW];

  always_comb begin
    o_req_grant = '0;
    if (w_fill) o_req_grant[w_win] = 1'b1;
  end

  assign o_out_send = r_full[w_drain_vc] & i_out_ready;
  assign o_out_data = r_full[w_drain_vc] ? r_buf[w_drain_vc] : '0;
  assign o_vc_full  = r_full;

  // Fill and drain always address different VCs, so each entry sees at most one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 2'b00;
      for (int v = 0; v < 2; v++) begin
        r_buf[v]    <= '0;
        r_rr_ptr[v] <= '0;
      end
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (w_fill && (w_fill_vc == 1'(v))) begin
          r_buf[v]    <= w_win_data;
          r_full[v]   <= 1'b1;
          r_rr_ptr[v] <= w_ptr_next;
        end else if (o_out_send && (w_drain_vc == 1'(v))) begin
          r_full[v]   <= 1'b0;
        end
      end
    end
  end

endmodule
